// File: rtl/scs8hd_bufinv_pipe.sv
// scs8hd_bufinv_pipe
// Elastic, registered bus driver for long, high-fanout buses. Each accepted
// word is either inverted or passed through, as selected by MODE when the
// word is captured. The word then moves through DEPTH register stages under
// valid/ready flow control. COUNT reports how many stages are occupied.

module scs8hd_bufinv_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] A,
    input  logic             A_VALID,
    output logic             A_READY,
    input  logic             MODE,
    output logic [WIDTH-1:0] Y,
    output logic             Y_VALID,
    input  logic             Y_READY,
    output logic [CW-1:0]    COUNT
`ifdef SC_USE_PG_PIN
    ,
    input  logic             vpwr,
    input  logic             vgnd,
    input  logic             vpb,
    input  logic             vnb
`endif
);

`ifndef SC_USE_PG_PIN
    supply1 vpwr;
    supply0 vgnd;
    supply1 vpb;
    supply0 vnb;
`endif

    // Stage i holds data_q[i] and valid_q[i].
    // Stage DEPTH-1 drives Y.
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    count_q;

    // ready[i] is high when stage i can load this cycle.
    logic [DEPTH-1:0] ready;
    logic             xfer_in;
    logic             xfer_out;
    logic             pg_good;
    logic             unused_bias;

    // Ready chain, computed from Y_READY back to stage 0.
    // A stage can load when it is empty or when its word is moving on.
    always_comb begin
        logic chain;
        // NOTE: each output of a combinational block gets a default first; without it, a missed path infers a latch.
        ready = '0;
        chain = Y_READY;
        // NOTE: blocking '=' is used here on purpose. Within one pass, 'chain' has to carry each stage's result into the next stage down.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain    = !valid_q[i] || chain;
            ready[i] = chain;
        end
    end

    assign A_READY  = ready[0] && !RESET;
    assign xfer_in  = A_VALID && A_READY;
    assign xfer_out = valid_q[DEPTH-1] && Y_READY;

    // Stage registers and the occupancy counter.
    // MODE is applied only at capture, so words already in flight never change.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            // NOTE: the data registers are cleared too. Y must read zero after reset, not only Y_VALID.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            if (ready[0]) begin
                valid_q[0] <= A_VALID;
                if (A_VALID) begin
                    data_q[0] <= MODE ? ~A : A;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (ready[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
            case ({xfer_in, xfer_out})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Outputs read X while the supply rails are not at their proper levels.
    assign pg_good     = (vpwr === 1'b1) && (vgnd === 1'b0);
    assign Y           = pg_good ? data_q[DEPTH-1] : {WIDTH{1'bx}};
    assign Y_VALID     = pg_good ? valid_q[DEPTH-1] : 1'bx;
    assign COUNT       = count_q;

    // The well-bias pins carry no logic function.
    assign unused_bias = vpb ^ vnb;

endmodule

// File: tb/tb_scs8hd_bufinv_pipe.sv
// Testbench for scs8hd_bufinv_pipe.
// Two instances, with DEPTH=2 and DEPTH=4, share one set of inputs. A
// scoreboard holds the words accepted but not yet emitted, tagged with the
// instance depth and the capture edge. From it the bench predicts COUNT,
// A_READY, Y_VALID and Y in every cycle.

module tb_scs8hd_bufinv_pipe;

    logic        clk;
    logic        rst;
    logic [15:0] a_in;
    logic        av_in;
    logic        mode_in;
    logic        yr_in;

    logic        rdy2, yv2;
    logic [15:0] y2;
    logic [1:0]  cnt2;
    logic        rdy4, yv4;
    logic [15:0] y4;
    logic [2:0]  cnt4;

    scs8hd_bufinv_pipe #(.WIDTH(16), .DEPTH(2)) dut2 (
        .CLK(clk), .RESET(rst), .A(a_in), .A_VALID(av_in), .A_READY(rdy2),
        .MODE(mode_in), .Y(y2), .Y_VALID(yv2), .Y_READY(yr_in), .COUNT(cnt2)
    );

    scs8hd_bufinv_pipe #(.WIDTH(16), .DEPTH(4)) dut4 (
        .CLK(clk), .RESET(rst), .A(a_in), .A_VALID(av_in), .A_READY(rdy4),
        .MODE(mode_in), .Y(y4), .Y_VALID(yv4), .Y_READY(yr_in), .COUNT(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;   // word as it must appear on Y
        int          t;   // edge number at which it was captured
        int          d;   // depth of the instance that holds it
    } ent_t;

    ent_t        sb [$];
    int          ecount = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_in4 = 0;
    int          n_out4 = 0;
    logic [4:0]  stall_prev = '0;
    logic [15:0] prev_y [5];
    logic [15:0] y2_seen [$];
    logic [15:0] y4_seen [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    endtask

    // Compare one instance against the scoreboard before the coming edge.
    task automatic check_depth(input int d, input logic r, input logic av, input logic yr,
                               input logic rdy, input logic yv, input logic [15:0] y,
                               input logic [31:0] cnt, output logic xin, output logic xout);
        int   n;
        int   f;
        logic exp_v;
        n = 0;
        f = -1;
        xin = 1'b0;
        xout = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].d == d) begin
                if (f < 0) f = i;
                n++;
            end
        end
        if (r) begin
            check($sformatf("a_ready_in_reset_d%0d", d), rdy, 0);
        end else begin
            check($sformatf("count_d%0d", d), cnt, n);
            check($sformatf("a_ready_d%0d", d), rdy, !(n == d && !yr));
            exp_v = (n > 0) && (ecount >= sb[f].t + d - 1);
            check($sformatf("y_valid_d%0d", d), yv, exp_v);
            if (exp_v && yv) check($sformatf("y_data_d%0d", d), y, sb[f].w);
            if (stall_prev[d]) begin
                check($sformatf("stall_valid_d%0d", d), yv, 1);
                check($sformatf("stall_data_d%0d", d), y, prev_y[d]);
            end
            stall_prev[d] = yv && !yr;
            prev_y[d]     = y;
            xin  = av && rdy;
            xout = yv && yr;
        end
    endtask

    task automatic pop_front(input int d);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].d == d) idx = i;
        end
        if (idx >= 0) sb.delete(idx);
    endtask

    // Drive one cycle's inputs at the negedge, check both instances, then
    // advance the scoreboard at the posedge.
    task automatic cycle(input logic r, input logic v, input logic [15:0] a,
                         input logic m, input logic yr);
        logic        xi2, xo2, xi4, xo4;
        logic [15:0] w;
        @(negedge clk);
        rst = r; a_in = a; av_in = v; mode_in = m; yr_in = yr;
        #1;
        check_depth(2, r, v, yr, rdy2, yv2, y2, 32'(cnt2), xi2, xo2);
        check_depth(4, r, v, yr, rdy4, yv4, y4, 32'(cnt4), xi4, xo4);
        if (xo2) y2_seen.push_back(y2);
        if (xo4) y4_seen.push_back(y4);
        if (xi4) n_in4++;
        if (xo4) n_out4++;
        w = m ? ~a : a;
        @(posedge clk);
        ecount++;
        if (r) begin
            sb.delete();
            stall_prev = '0;
        end else begin
            if (xo2) pop_front(2);
            if (xo4) pop_front(4);
            if (xi2) sb.push_back('{w, ecount, 2});
            if (xi4) sb.push_back('{w, ecount, 4});
        end
    endtask

    logic [15:0] mix_exp [3];
    logic [15:0] bp_exp  [4];

    initial begin
        rst = 1'b1; a_in = '0; av_in = 1'b0; mode_in = 1'b0; yr_in = 1'b1;
        mix_exp = '{16'hFF00, 16'h1234, 16'h0000};
        bp_exp  = '{16'd1, 16'd2, 16'd3, 16'd4};

        // Reset and idle state.
        cycle(1, 0, 16'h0, 0, 1);
        cycle(1, 0, 16'h0, 0, 1);
        @(negedge clk);
        rst = 1'b0; av_in = 1'b0; yr_in = 1'b1;
        #1;
        check("rst_y_d2", y2, 16'h0000);
        check("rst_yv_d2", yv2, 0);
        check("rst_cnt_d2", cnt2, 0);
        check("rst_rdy_d2", rdy2, 1);
        check("rst_y_d4", y4, 16'h0000);
        check("rst_yv_d4", yv4, 0);
        check("rst_cnt_d4", cnt4, 0);
        check("rst_rdy_d4", rdy4, 1);

        // Mode mix on the DEPTH=2 instance.
        y2_seen.delete();
        cycle(0, 1, 16'h00FF, 1, 1);
        cycle(0, 1, 16'h1234, 0, 1);
        cycle(0, 1, 16'hFFFF, 1, 1);
        repeat (5) cycle(0, 0, 16'h0, 0, 1);
        check("mix_count", y2_seen.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mix_word%0d", i), (i < y2_seen.size()) ? y2_seen[i] : 16'hxxxx, mix_exp[i]);
        end

        // Backpressure: fill with Y_READY low, then drain.
        y4_seen.delete();
        for (int i = 1; i <= 6; i++) cycle(0, 1, 16'(i), 0, 0);
        #1;
        check("bp_full_count_d4", cnt4, 4);
        check("bp_full_ready_d4", rdy4, 0);
        check("bp_full_count_d2", cnt2, 2);
        repeat (8) cycle(0, 0, 16'h0, 0, 1);
        check("bp_drain_count", y4_seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_word%0d", i), (i < y4_seen.size()) ? y4_seen[i] : 16'hxxxx, bp_exp[i]);
        end

        // Full pipeline with simultaneous input and output.
        repeat (4) cycle(0, 1, 16'($urandom), 1'($urandom), 0);
        n_in4 = 0;
        n_out4 = 0;
        for (int i = 0; i < 10; i++) cycle(0, 1, 16'(16'h100 + i), 1'($urandom), 1);
        #1;
        check("sim_in", n_in4, 10);
        check("sim_out", n_out4, 10);
        check("sim_count", cnt4, 4);
        repeat (6) cycle(0, 0, 16'h0, 0, 1);

        // Reset while words are in flight.
        cycle(0, 1, 16'hAAAA, 0, 0);
        cycle(0, 1, 16'hBBBB, 0, 0);
        cycle(0, 1, 16'hCCCC, 0, 0);
        cycle(1, 0, 16'h0, 0, 0);
        #1;
        check("midrst_yv_d4", yv4, 0);
        check("midrst_cnt_d4", cnt4, 0);
        check("midrst_yv_d2", yv2, 0);
        check("midrst_cnt_d2", cnt2, 0);
        repeat (6) cycle(0, 0, 16'h0, 0, 1);

        // Random traffic with occasional resets.
        repeat (600) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
        end
        repeat (8) cycle(0, 0, 16'h0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
